// File: rtl/dsa_sched_pkg.sv
// Shared types and helpers for the multi-lane bilinear work scheduler.
package dsa_sched_pkg;

  localparam int Q_FRAC = 8;
  localparam int DESC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EMIT,
    S_WAIT,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [DESC_W-1:0] addr;
    logic [DESC_W-1:0] x0;
    logic [DESC_W-1:0] x1;
    logic [Q_FRAC-1:0] fx;
  } lane_desc_t;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/dsa_coord_clamp.sv
// Splits a Q8.8 source coordinate into integer/fraction and clamps the integer
// part (and its +1 neighbour) to the last valid index of the dimension.
module dsa_coord_clamp
  import dsa_sched_pkg::*;
#(
  parameter int DIM_W = 16
) (
  input  logic [2*DIM_W-1:0] q_i,
  input  logic [DIM_W-1:0]   lim_i,
  output logic [DIM_W-1:0]   i0_o,
  output logic [DIM_W-1:0]   i1_o,
  output logic [Q_FRAC-1:0]  frac_o
);

  localparam int IW = 2*DIM_W - Q_FRAC;

  logic [IW-1:0] int_w;
  logic [IW-1:0] last_w;

  assign int_w  = q_i[2*DIM_W-1:Q_FRAC];
  assign last_w = IW'(lim_i) - IW'(1);

  assign i0_o   = (int_w > last_w)  ? DIM_W'(last_w) : DIM_W'(int_w);
  assign i1_o   = (int_w >= last_w) ? DIM_W'(last_w) : DIM_W'(int_w + IW'(1));
  assign frac_o = q_i[Q_FRAC-1:0];

endmodule

// File: rtl/dsa_simd_sched.sv
// Multi-lane bilinear work scheduler: emits batches of LANES output pixels with
// source coordinates and Q8.8 weights. Optional counters: DSA_SCHED_PERF_EN.
module dsa_simd_sched
  import dsa_sched_pkg::*;
#(
  parameter int LANES = 4,
  parameter int AW    = 12,
  parameter int DIM_W = 16,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step_en,
  input  logic                   step_pulse,
  input  logic [DIM_W-1:0]       cfg_in_w,
  input  logic [DIM_W-1:0]       cfg_in_h,
  input  logic [DIM_W-1:0]       cfg_scale_q88,
  input  logic [DIM_W-1:0]       cfg_inv_q88,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DIM_W-1:0]       out_w,
  output logic [DIM_W-1:0]       out_h,
  output logic                   bat_valid,
  input  logic                   bat_ready,
  output logic [LANES-1:0]       bat_mask,
  output logic [LANES*AW-1:0]    bat_addr,
  output logic [LANES*DIM_W-1:0] bat_x0,
  output logic [LANES*DIM_W-1:0] bat_x1,
  output logic [DIM_W-1:0]       bat_y0,
  output logic [DIM_W-1:0]       bat_y1,
  output logic [LANES*8-1:0]     bat_fx,
  output logic [7:0]             bat_fy,
  output logic [CNT_W-1:0]       perf_batches,
  output logic [CNT_W-1:0]       perf_pixels,
  output logic [CNT_W-1:0]       perf_stalls
);

  localparam int ACC_W = 2*DIM_W;
  localparam int PW    = $clog2(LANES+1);
  localparam logic [ACC_W:0] AREA_MAX = {{ACC_W{1'b0}}, 1'b1} << AW;

  sched_state_e     state_q, state_d;
  logic             err_q, err_d;
  logic [DIM_W-1:0] out_w_q, out_w_d, out_h_q, out_h_d;
  logic [DIM_W-1:0] in_w_q, in_w_d, in_h_q, in_h_d, inv_q, inv_d;
  logic [ACC_W-1:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [AW-1:0]    addr_q, addr_d;

  logic [ACC_W-1:0] inv_ext;
  logic [ACC_W-1:0] prod_w, prod_h, area;
  logic [DIM_W-1:0] out_w_calc, out_h_calc;
  logic             cfg_bad;
  logic             row_end, last_row;
  logic [PW-1:0]    pix_cnt;

  assign inv_ext = {{DIM_W{1'b0}}, inv_q};

  assign prod_w     = {{DIM_W{1'b0}}, cfg_in_w} * {{DIM_W{1'b0}}, cfg_scale_q88};
  assign prod_h     = {{DIM_W{1'b0}}, cfg_in_h} * {{DIM_W{1'b0}}, cfg_scale_q88};
  assign out_w_calc = DIM_W'(sat16(32'(prod_w >> Q_FRAC)));
  assign out_h_calc = DIM_W'(sat16(32'(prod_h >> Q_FRAC)));
  assign area       = {{DIM_W{1'b0}}, out_w_calc} * {{DIM_W{1'b0}}, out_h_calc};

  assign cfg_bad = (out_w_calc == '0) || (out_h_calc == '0) || (cfg_in_w == '0) ||
                   (cfg_in_h == '0) || (cfg_inv_q88 == '0) || ({1'b0, area} > AREA_MAX);

  // A batch is always cut at the row boundary so y0/y1/fy can be shared.
  assign row_end  = ({1'b0, col_q} + (DIM_W+1)'(LANES)) >= {1'b0, out_w_q};
  assign last_row = (row_q == out_h_q - DIM_W'(1));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ACC_W-1:0] sx;
    assign sx = x_acc_q + inv_ext * ACC_W'(gi);
    assign bat_mask[gi] = ({1'b0, col_q} + (DIM_W+1)'(gi)) < {1'b0, out_w_q};
    assign bat_addr[gi*AW +: AW] = addr_q + AW'(gi);

    dsa_coord_clamp #(.DIM_W(DIM_W)) u_x_clamp (
      .q_i    (sx),
      .lim_i  (in_w_q),
      .i0_o   (bat_x0[gi*DIM_W +: DIM_W]),
      .i1_o   (bat_x1[gi*DIM_W +: DIM_W]),
      .frac_o (bat_fx[gi*8 +: 8])
    );
  end

  dsa_coord_clamp #(.DIM_W(DIM_W)) u_y_clamp (
    .q_i    (y_acc_q),
    .lim_i  (in_h_q),
    .i0_o   (bat_y0),
    .i1_o   (bat_y1),
    .frac_o (bat_fy)
  );

  always_comb begin
    pix_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      pix_cnt = pix_cnt + PW'(bat_mask[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    out_w_d = out_w_q;
    out_h_d = out_h_q;
    in_w_d  = in_w_q;
    in_h_d  = in_h_q;
    inv_d   = inv_q;
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        in_w_d  = cfg_in_w;
        in_h_d  = cfg_in_h;
        inv_d   = cfg_inv_q88;
        out_w_d = out_w_calc;
        out_h_d = out_h_calc;
        x_acc_d = '0;
        y_acc_d = '0;
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = step_en ? S_WAIT : S_EMIT;
        end
      end
      S_EMIT: begin
        if (bat_ready) begin
          addr_d = addr_q + AW'(pix_cnt);
          if (row_end) begin
            col_d   = '0;
            x_acc_d = '0;
            y_acc_d = y_acc_q + inv_ext;
            row_d   = row_q + DIM_W'(1);
          end else begin
            col_d   = col_q + DIM_W'(LANES);
            x_acc_d = x_acc_q + inv_ext * ACC_W'(LANES);
          end
          if (row_end && last_row) begin
            state_d = S_DONE;
          end else if (step_en) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!step_en || step_pulse) begin
          state_d = S_EMIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      out_w_q <= '0;
      out_h_q <= '0;
      in_w_q  <= '0;
      in_h_q  <= '0;
      inv_q   <= '0;
      x_acc_q <= '0;
      y_acc_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      out_w_q <= out_w_d;
      out_h_q <= out_h_d;
      in_w_q  <= in_w_d;
      in_h_q  <= in_h_d;
      inv_q   <= inv_d;
      x_acc_q <= x_acc_d;
      y_acc_q <= y_acc_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign out_w     = out_w_q;
  assign out_h     = out_h_q;
  assign bat_valid = (state_q == S_EMIT);

`ifdef DSA_SCHED_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] perf_batches_q, perf_pixels_q, perf_stalls_q;
  logic             xfer;

  assign xfer = bat_valid && bat_ready;

  always_ff @(posedge clk) begin
    if (rst || ((state_q == S_IDLE) && start)) begin
      perf_batches_q <= '0;
      perf_pixels_q  <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (xfer && (perf_batches_q != CNT_MAX)) begin
        perf_batches_q <= perf_batches_q + CNT_W'(1);
      end
      if (xfer) begin
        perf_pixels_q <= ((CNT_MAX - perf_pixels_q) < CNT_W'(pix_cnt)) ?
                         CNT_MAX : perf_pixels_q + CNT_W'(pix_cnt);
      end
      if (bat_valid && !bat_ready && (perf_stalls_q != CNT_MAX)) begin
        perf_stalls_q <= perf_stalls_q + CNT_W'(1);
      end
    end
  end

  assign perf_batches = perf_batches_q;
  assign perf_pixels  = perf_pixels_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_batches = '0;
  assign perf_pixels  = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_dsa_simd_sched.sv
// Directed self-checking bench for dsa_simd_sched (LANES=4, AW=12).
`timescale 1ns/1ps
module tb_dsa_simd_sched;
  import dsa_sched_pkg::*;

  localparam int LANES = 4;
  localparam int AW    = 12;
  localparam int DIM_W = 16;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   rst, start, step_en, step_pulse, bat_ready;
  logic [DIM_W-1:0]       cfg_in_w, cfg_in_h, cfg_scale_q88, cfg_inv_q88;
  logic                   busy, done, err, bat_valid;
  logic [DIM_W-1:0]       out_w, out_h, bat_y0, bat_y1;
  logic [LANES-1:0]       bat_mask;
  logic [LANES*AW-1:0]    bat_addr;
  logic [LANES*DIM_W-1:0] bat_x0, bat_x1;
  logic [LANES*8-1:0]     bat_fx;
  logic [7:0]             bat_fy;
  logic [CNT_W-1:0]       perf_batches, perf_pixels, perf_stalls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsa_simd_sched #(.LANES(LANES), .AW(AW), .DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .step_en(step_en), .step_pulse(step_pulse),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
    .cfg_inv_q88(cfg_inv_q88), .busy(busy), .done(done), .err(err),
    .out_w(out_w), .out_h(out_h), .bat_valid(bat_valid), .bat_ready(bat_ready),
    .bat_mask(bat_mask), .bat_addr(bat_addr), .bat_x0(bat_x0), .bat_x1(bat_x1),
    .bat_y0(bat_y0), .bat_y1(bat_y1), .bat_fx(bat_fx), .bat_fy(bat_fy),
    .perf_batches(perf_batches), .perf_pixels(perf_pixels), .perf_stalls(perf_stalls)
  );

  function automatic lane_desc_t get_lane(input int k);
    lane_desc_t d;
    d.addr = 16'(bat_addr[k*AW +: AW]);
    d.x0   = bat_x0[k*DIM_W +: DIM_W];
    d.x1   = bat_x1[k*DIM_W +: DIM_W];
    d.fx   = bat_fx[k*8 +: 8];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int sc, input int inv);
    cfg_in_w      = DIM_W'(w);
    cfg_in_h      = DIM_W'(h);
    cfg_scale_q88 = DIM_W'(sc);
    cfg_inv_q88   = DIM_W'(inv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_xfer, stalls, cyc;
    logic hold, done_seen;
    logic [LANES*AW-1:0]    sv_addr;
    logic [LANES*DIM_W-1:0] sv_x0;
    logic [LANES*8-1:0]     sv_fx;

    rst = 1'b1; start = 1'b0; step_en = 1'b0; step_pulse = 1'b0; bat_ready = 1'b1;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", bat_valid, 0);
    chk("rst_out_w", out_w, 0);
    chk("rst_out_h", out_h, 0);
    chk("rst_perf_b", perf_batches, 0);
    rst = 1'b0;
    @(negedge clk);

    // 10x2, scale 1: three batches per row, last one half full
    set_cfg(10, 2, 'h100, 'h100);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("a_busy_t1", busy, 1);
    chk("a_valid_t1", bat_valid, 0);
    @(negedge clk);
    chk("a_valid_t2", bat_valid, 1);
    chk("a_out_w", out_w, 10);
    chk("a_out_h", out_h, 2);
    chk("a_b0_mask", bat_mask, 4'b1111);
    chk("a_b0_l3_addr", get_lane(3).addr, 3);
    chk("a_b0_l3_x0", get_lane(3).x0, 3);
    chk("a_b0_l3_x1", get_lane(3).x1, 4);
    chk("a_b0_l0_fx", get_lane(0).fx, 0);
    chk("a_b0_y0", bat_y0, 0);
    chk("a_b0_y1", bat_y1, 1);
    @(negedge clk);
    chk("a_b1_l0_x0", get_lane(0).x0, 4);
    chk("a_b1_l0_addr", get_lane(0).addr, 4);
    @(negedge clk);
    chk("a_b2_mask", bat_mask, 4'b0011);
    chk("a_b2_l0_addr", get_lane(0).addr, 8);
    chk("a_b2_l1_addr", get_lane(1).addr, 9);
    chk("a_b2_l1_x1", get_lane(1).x1, 9);
    chk("a_b2_l2_x0", get_lane(2).x0, 9);
    @(negedge clk);
    chk("a_r1_y0", bat_y0, 1);
    chk("a_r1_y1", bat_y1, 1);
    chk("a_r1_l0_addr", get_lane(0).addr, 10);
    chk("a_r1_l0_x0", get_lane(0).x0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("a_r1b2_mask", bat_mask, 4'b0011);
    chk("a_r1b2_l1_addr", get_lane(1).addr, 19);
    @(negedge clk);
    chk("a_done", done, 1);
    chk("a_done_busy", busy, 0);
    chk("a_done_valid", bat_valid, 0);
`ifdef DSA_SCHED_PERF_EN
    chk("a_perf_batches", perf_batches, 6);
    chk("a_perf_pixels", perf_pixels, 20);
    chk("a_perf_stalls", perf_stalls, 0);
`else
    chk("a_perf_batches", perf_batches, 0);
    chk("a_perf_pixels", perf_pixels, 0);
`endif
    @(negedge clk);
    chk("a_done_pulse", done, 0);

    // 8x8 upscaled x2 under random backpressure; last column/row clamp
    set_cfg(8, 8, 'h200, 'h80);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_xfer = 0; stalls = 0; hold = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      @(negedge clk);
      if (hold) begin
        chk("b_hold_valid", bat_valid, 1);
        chk("b_hold_addr", bat_addr, sv_addr);
        chk("b_hold_x0", bat_x0, sv_x0);
        chk("b_hold_fx", bat_fx, sv_fx);
        hold = 1'b0;
      end
      if (done) done_seen = 1'b1;
      bat_ready = 1'($urandom_range(0, 1));
      if (bat_valid && bat_ready) begin
        if (n_xfer == 0) begin
          chk("b_first_l1_x0", get_lane(1).x0, 0);
          chk("b_first_l1_x1", get_lane(1).x1, 1);
          chk("b_first_l1_fx", get_lane(1).fx, 'h80);
        end
        if (n_xfer == 63) begin
          chk("b_last_l0_x0", get_lane(0).x0, 6);
          chk("b_last_l0_x1", get_lane(0).x1, 7);
          chk("b_last_l3_x0", get_lane(3).x0, 7);
          chk("b_last_l3_x1", get_lane(3).x1, 7);
          chk("b_last_l3_fx", get_lane(3).fx, 'h80);
          chk("b_last_y0", bat_y0, 7);
          chk("b_last_y1", bat_y1, 7);
          chk("b_last_fy", bat_fy, 'h80);
          chk("b_last_l3_addr", get_lane(3).addr, 255);
        end
        n_xfer++;
      end else if (bat_valid) begin
        stalls++;
        hold    = 1'b1;
        sv_addr = bat_addr;
        sv_x0   = bat_x0;
        sv_fx   = bat_fx;
      end
    end
    bat_ready = 1'b1;
    chk("b_done_seen", done_seen, 1);
    chk("b_batches", n_xfer, 64);
    chk("b_out_w", out_w, 16);
`ifdef DSA_SCHED_PERF_EN
    chk("b_perf_stalls", perf_stalls, stalls);
    chk("b_perf_pixels", perf_pixels, 256);
`else
    chk("b_perf_stalls", perf_stalls, 0);
`endif
    @(negedge clk);

    // single-step mode, plus a start with different config while busy
    set_cfg(10, 2, 'h100, 'h100);
    step_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("c_wait_valid", bat_valid, 0);
    chk("c_wait_busy", busy, 1);
    cfg_in_w = 16'd20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("c_wait_valid2", bat_valid, 0);
    step_pulse = 1'b1;
    @(negedge clk); step_pulse = 1'b0;
    chk("c_s1_valid", bat_valid, 1);
    chk("c_s1_l0_x0", get_lane(0).x0, 0);
    chk("c_s1_out_w", out_w, 10);
    @(negedge clk);
    chk("c_s1_after", bat_valid, 0);
    @(negedge clk);
    chk("c_s1_idle", bat_valid, 0);
    step_pulse = 1'b1;
    @(negedge clk); step_pulse = 1'b0;
    chk("c_s2_valid", bat_valid, 1);
    chk("c_s2_l0_x0", get_lane(0).x0, 4);
    chk("c_s2_l0_addr", get_lane(0).addr, 4);
    @(negedge clk);
    chk("c_s2_after", bat_valid, 0);
    step_en = 1'b0;
    @(negedge clk);
    chk("c_resume_valid", bat_valid, 1);
    chk("c_resume_mask", bat_mask, 4'b0011);
    chk("c_resume_l0_addr", get_lane(0).addr, 8);
    chk("c_resume_l1_x1", get_lane(1).x1, 9);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("c_done", done, 1);
    chk("c_done_cycles", cyc, 4);
    chk("c_out_w_kept", out_w, 10);
    @(negedge clk);

    // illegal configs: zero scale, and output larger than the address space
    set_cfg(64, 64, 'h000, 'h080);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("d0_busy", busy, 1);
    @(negedge clk);
    chk("d0_done", done, 1);
    chk("d0_err", err, 1);
    chk("d0_valid", bat_valid, 0);
    chk("d0_busy_done", busy, 0);
    @(negedge clk);
    chk("d0_done_pulse", done, 0);
    chk("d0_err_sticky", err, 1);
    set_cfg(64, 64, 'h200, 'h080);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("d1_err_clr", err, 0);
    @(negedge clk);
    chk("d1_done", done, 1);
    chk("d1_err", err, 1);
    chk("d1_valid", bat_valid, 0);
    chk("d1_out_w", out_w, 128);
    chk("d1_out_h", out_h, 128);
    chk("d1_perf_b", perf_batches, 0);
    @(negedge clk);

    // synchronous reset while a batch is stalled
    set_cfg(10, 2, 'h100, 'h100);
    bat_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("e_valid", bat_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("e_busy", busy, 0);
    chk("e_valid_rst", bat_valid, 0);
    chk("e_out_w", out_w, 0);
    chk("e_out_h", out_h, 0);
    chk("e_err", err, 0);
    chk("e_done", done, 0);
    chk("e_perf_s", perf_stalls, 0);
    rst = 1'b0; bat_ready = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
